// File: rtl/comma_aligner_pkg.sv
// Shared constants and types for the receive word aligner.
// Comma patterns, symbol width and sync-FSM state encoding.
package comma_aligner_pkg;

    localparam int SYM_W = 10;

    localparam logic [6:0] COMMA_P = 7'b0011111;
    localparam logic [6:0] COMMA_N = 7'b1100000;

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } state_e;

    // abcdeif of a symbol is a comma in either disparity
    function automatic logic is_comma(input logic [6:0] hi);
        return (hi == COMMA_P) || (hi == COMMA_N);
    endfunction

endpackage

// File: rtl/comma_finder.sv
// Combinational comma search over the ten bit offsets of a
// two-word window; the lowest matching offset wins.
module comma_finder
    import comma_aligner_pkg::*;
(
    input  logic [2*SYM_W-1:0]          win_i,
    output logic                        cdet_o,
    output logic [3:0]                  ck_o,
    output logic [SYM_W-1:0][SYM_W-1:0] cand_o
);

    // Bit 0 would only start a candidate at offset 10, which is
    // offset 0 of the following window.
    logic unused_lsb;
    assign unused_lsb = win_i[0];

    // Slice every candidate; scan high-to-low so the lowest match sticks
    always_comb begin
        logic [SYM_W-1:0] c;
        cdet_o = 1'b0;
        ck_o   = '0;
        cand_o = '0;
        for (int k = SYM_W-1; k >= 0; k--) begin
            c = win_i[2*SYM_W-1-k -: SYM_W];
            cand_o[k] = c;
            if (is_comma(c[SYM_W-1:SYM_W-7])) begin
                cdet_o = 1'b1;
                ck_o   = 4'(k);
            end
        end
    end

endmodule

// File: rtl/comma_aligner.sv
// Receive word aligner: locks a bit offset on commas and
// runs LOS/ACQ/SYNC using decoder code violations as feedback.
module comma_aligner
    import comma_aligner_pkg::*;
#(
    parameter int ACQ_COMMAS = 3,
    parameter int LOSS_ERRS  = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [SYM_W-1:0] raw_in,
    input  logic             raw_valid,
    input  logic             code_err,
    output logic [SYM_W-1:0] data_out,
    output logic             valid_out,
    output logic             comma_out,
    output logic             synced,
    output logic [3:0]       offset
);

    state_e           state_q;
    logic [1:0]       cnt_q;
    logic [2:0]       errcnt_q;
    logic [3:0]       offset_q;
    logic [3:0]       offset_d;
    logic [SYM_W-1:0] prev_q;
    logic [SYM_W-1:0] data_q;
    logic             valid_q;
    logic             comma_q;

    logic                        cdet;
    logic [3:0]                  ck;
    logic [SYM_W-1:0][SYM_W-1:0] cand;
    logic [SYM_W-1:0]            sel;
    logic                        err;

    comma_finder u_finder (
        .win_i  ({prev_q, raw_in}),
        .cdet_o (cdet),
        .ck_o   (ck),
        .cand_o (cand)
    );

    // A violation only counts against a word we actually presented
    assign err = code_err & valid_q;

    // Offset after this word's update, so a realigning comma is
    // itself emitted aligned; an error in ACQ suppresses realign
    always_comb begin
        offset_d = offset_q;
        if (cdet && (state_q == LOS))
            offset_d = ck;
        if (cdet && (state_q == ACQ) && !err)
            offset_d = ck;
    end

    assign sel = cand[offset_d];

    // Sync FSM plus registered output word, advanced per valid word
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q  <= LOS;
            cnt_q    <= '0;
            errcnt_q <= '0;
            offset_q <= '0;
            prev_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            comma_q  <= 1'b0;
        end else if (raw_valid) begin
            prev_q   <= raw_in;
            valid_q  <= 1'b1;
            data_q   <= sel;
            comma_q  <= is_comma(sel[SYM_W-1:SYM_W-7]);
            offset_q <= offset_d;
            unique case (state_q)
                LOS: begin
                    if (cdet) begin
                        state_q <= ACQ;
                        cnt_q   <= 2'd1;
                    end
                end
                ACQ: begin
                    if (err) begin
                        state_q <= LOS;
                        cnt_q   <= '0;
                    end else if (cdet && (ck == offset_q)) begin
                        if (cnt_q == 2'(ACQ_COMMAS-1)) begin
                            state_q <= SYNC;
                            cnt_q   <= '0;
                        end else if (cnt_q != 2'd3) begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end else if (cdet) begin
                        cnt_q <= 2'd1;
                    end
                end
                SYNC: begin
                    if (!err) begin
                        errcnt_q <= '0;
                    end else if (errcnt_q == 3'(LOSS_ERRS-1)) begin
                        state_q  <= LOS;
                        errcnt_q <= '0;
                    end else begin
                        errcnt_q <= errcnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= LOS;
                end
            endcase
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign comma_out = comma_q;
    assign synced    = (state_q == SYNC);
    assign offset    = offset_q;

endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: symbols are serialized and
// shifted by k bits before being cut into raw words.
module tb_comma_aligner;

    localparam logic [9:0] K_N = 10'b0011111010;
    localparam logic [9:0] K_P = 10'b1100000101;
    localparam logic [9:0] D21 = 10'b1010101010;
    localparam logic [9:0] ZW  = 10'b0000000000;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [9:0] raw_in;
    logic       raw_valid;
    logic       code_err;
    logic [9:0] data_out;
    logic       valid_out;
    logic       comma_out;
    logic       synced;
    logic [3:0] offset;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0]  prev_sym;
    logic [16:0] obs;

    always #5 clk = ~clk;

    comma_aligner dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .raw_in    (raw_in),
        .raw_valid (raw_valid),
        .code_err  (code_err),
        .data_out  (data_out),
        .valid_out (valid_out),
        .comma_out (comma_out),
        .synced    (synced),
        .offset    (offset)
    );

    assign obs = {valid_out, comma_out, synced, offset, data_out};

    function automatic logic [16:0] ev(input bit v, input bit c,
                                       input bit s, input bit [3:0] o,
                                       input logic [9:0] d);
        return {v, c, s, o, d};
    endfunction

    task automatic step(input logic [9:0] w, input logic v, input logic e);
        raw_in    = w;
        raw_valid = v;
        code_err  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] sym, input int k, input logic e);
        logic [19:0] cat;
        cat = {prev_sym, sym} >> k;
        prev_sym = sym;
        step(cat[9:0], 1'b1, e);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        step(ZW, 1'b0, 1'b0);
        reset_L  = 1'b1;
        prev_sym = ZW;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(10'($urandom), 1'($urandom), 1'($urandom));
            n_tests++;
            if (obs !== 17'd0) begin
                n_fail++;
                $display("FAIL reset[%0d] got %h want %h", i, obs, 17'd0);
            end
        end
        reset_L  = 1'b1;
        prev_sym = ZW;
    endtask

    task automatic test_acquire();
        logic [9:0]  sy[7];
        logic [16:0] ex[7];
        do_reset();
        sy = '{K_N, K_P, K_N, K_P, D21, D21, D21};
        ex = '{ev(1'b1, 1'b0, 1'b0, 4'd0, ZW),
               ev(1'b1, 1'b1, 1'b0, 4'd3, K_N),
               ev(1'b1, 1'b1, 1'b0, 4'd3, K_P),
               ev(1'b1, 1'b1, 1'b1, 4'd3, K_N),
               ev(1'b1, 1'b1, 1'b1, 4'd3, K_P),
               ev(1'b1, 1'b0, 1'b1, 4'd3, D21),
               ev(1'b1, 1'b0, 1'b1, 4'd3, D21)};
        for (int i = 0; i < 7; i++) begin
            send(sy[i], 3, 1'b0);
            n_tests++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL acquire[%0d] got %h want %h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_realign();
        logic [9:0]  sy[8];
        int          ks[8];
        logic [16:0] ex[8];
        do_reset();
        sy = '{K_N, K_P, D21, K_N, K_P, K_N, K_P, K_N};
        ks = '{3, 3, 3, 7, 7, 7, 7, 7};
        ex = '{ev(1'b1, 1'b0, 1'b0, 4'd0, ZW),
               ev(1'b1, 1'b1, 1'b0, 4'd3, K_N),
               ev(1'b1, 1'b1, 1'b0, 4'd3, K_P),
               ev(1'b1, 1'b0, 1'b0, 4'd3, D21),
               ev(1'b1, 1'b1, 1'b0, 4'd7, K_N),
               ev(1'b1, 1'b1, 1'b0, 4'd7, K_P),
               ev(1'b1, 1'b1, 1'b1, 4'd7, K_N),
               ev(1'b1, 1'b1, 1'b1, 4'd7, K_P)};
        for (int i = 0; i < 8; i++) begin
            send(sy[i], ks[i], 1'b0);
            n_tests++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL realign[%0d] got %h want %h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_loss();
        logic [9:0]  sy[14];
        int          ks[14];
        logic        er[14];
        logic [16:0] ex[14];
        do_reset();
        sy = '{K_N, K_P, K_N, K_P, D21, D21, D21, D21,
               D21, D21, D21, D21, K_N, K_P};
        ks = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 5, 5};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        ex = '{ev(1'b1, 1'b0, 1'b0, 4'd0, ZW),
               ev(1'b1, 1'b1, 1'b0, 4'd3, K_N),
               ev(1'b1, 1'b1, 1'b0, 4'd3, K_P),
               ev(1'b1, 1'b1, 1'b1, 4'd3, K_N),
               ev(1'b1, 1'b1, 1'b1, 4'd3, K_P),
               ev(1'b1, 1'b0, 1'b1, 4'd3, D21),
               ev(1'b1, 1'b0, 1'b1, 4'd3, D21),
               ev(1'b1, 1'b0, 1'b1, 4'd3, D21),
               ev(1'b1, 1'b0, 1'b1, 4'd3, D21),
               ev(1'b1, 1'b0, 1'b1, 4'd3, D21),
               ev(1'b1, 1'b0, 1'b1, 4'd3, D21),
               ev(1'b1, 1'b0, 1'b0, 4'd3, D21),
               ev(1'b1, 1'b0, 1'b0, 4'd3, D21),
               ev(1'b1, 1'b1, 1'b0, 4'd5, K_N)};
        for (int i = 0; i < 14; i++) begin
            send(sy[i], ks[i], er[i]);
            n_tests++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL loss[%0d] got %h want %h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_err_in_acq();
        logic [9:0]  sy[6];
        logic        er[6];
        logic [16:0] ex[6];
        do_reset();
        sy = '{K_N, K_P, K_N, K_P, K_N, K_P};
        er = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        ex = '{ev(1'b1, 1'b0, 1'b0, 4'd0, ZW),
               ev(1'b1, 1'b1, 1'b0, 4'd3, K_N),
               ev(1'b1, 1'b1, 1'b0, 4'd3, K_P),
               ev(1'b1, 1'b1, 1'b0, 4'd3, K_N),
               ev(1'b1, 1'b1, 1'b0, 4'd3, K_P),
               ev(1'b1, 1'b1, 1'b1, 4'd3, K_N)};
        for (int i = 0; i < 6; i++) begin
            send(sy[i], 3, er[i]);
            n_tests++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL err_acq[%0d] got %h want %h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_gap();
        logic [16:0] exp_gap;
        logic [16:0] exp_a;
        logic [16:0] exp_b;
        do_reset();
        send(K_N, 3, 1'b0);
        send(K_P, 3, 1'b0);
        exp_gap = ev(1'b0, 1'b1, 1'b0, 4'd3, K_N);
        for (int i = 0; i < 5; i++) begin
            step(10'h3FF, 1'b0, 1'b1);
            n_tests++;
            if (obs !== exp_gap) begin
                n_fail++;
                $display("FAIL gap[%0d] got %h want %h", i, obs, exp_gap);
            end
        end
        send(K_N, 3, 1'b1);
        exp_a = ev(1'b1, 1'b1, 1'b0, 4'd3, K_P);
        n_tests++;
        if (obs !== exp_a) begin
            n_fail++;
            $display("FAIL gap_resume got %h want %h", obs, exp_a);
        end
        send(K_P, 3, 1'b0);
        exp_b = ev(1'b1, 1'b1, 1'b1, 4'd3, K_N);
        n_tests++;
        if (obs !== exp_b) begin
            n_fail++;
            $display("FAIL gap_sync got %h want %h", obs, exp_b);
        end
    endtask

    task automatic test_midreset();
        logic [16:0] exp_r;
        exp_r = ev(1'b1, 1'b0, 1'b0, 4'd0, ZW);
        reset_L = 1'b0;
        step(10'($urandom), 1'b1, 1'b1);
        n_tests++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("FAIL midreset got %h want %h", obs, 17'd0);
        end
        reset_L  = 1'b1;
        prev_sym = ZW;
        send(K_N, 3, 1'b0);
        n_tests++;
        if (obs !== exp_r) begin
            n_fail++;
            $display("FAIL post_reset got %h want %h", obs, exp_r);
        end
    endtask

    initial begin
        reset_L   = 1'b0;
        raw_in    = ZW;
        raw_valid = 1'b0;
        code_err  = 1'b0;
        prev_sym  = ZW;
        test_reset();
        test_acquire();
        test_realign();
        test_loss();
        test_err_in_acq();
        test_gap();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule

// File: doc/comma_aligner.md
Name: comma_aligner

Overview:
- Receive-side word aligner that sits directly upstream of the 8b10b decoder.
- Takes unaligned 10-bit words from the deserializer, searches for the comma (abcdeif = 0011111 or 1100000, as in K28.1/K28.5/K28.7), and locks a bit offset.
- Outputs symbol-aligned 10-bit codes to the decoder.
- Runs a sync-acquisition/loss FSM that uses the decoder's code-violation flag as feedback.

Parameters:
- ACQ_COMMAS, 3, consecutive same-offset commas needed to declare sync.
- LOSS_ERRS, 4, consecutive errored words in sync that force loss of sync.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset_L  in  1  synchronous reset, active low.
- raw_in  in  10  unaligned word; bit 9 is the first bit received in time.
- raw_valid  in  1  raw_in is valid this cycle.
- code_err  in  1  decoder code violation for the word presented on data_out in the previous cycle.
- data_out  out  10  aligned symbol; bit 9 = a, bit 0 = j (decoder input order).
- valid_out  out  1  data_out is valid.
- comma_out  out  1  data_out contains a comma pattern.
- synced  out  1  FSM is in SYNC.
- offset  out  4  currently selected bit offset, 0..9.

Behaviour:
- Reset (reset_L=0 at a clock edge):
  - all outputs 0; offset=0; internal previous-word register=0.
  - FSM goes to LOS; counters are cleared.
  - Reset asserted mid-operation aborts everything on that same edge.
- Window:
  - On a raw_valid cycle, win[19:0] = {prev, raw_in}, then prev <= raw_in.
  - Candidate k (k = 0..9) is win[19-k -: 10].
  - When raw_valid=0, nothing updates and valid_out=0 on the next edge.
- Comma search:
  - Each candidate's bits [9:3] are compared against 0011111 and 1100000.
  - Matches at several offsets: the lowest k wins.
  - cdet = any match; ck = the winning k.
- Output timing:
  - Registered, latency 1. Input word at cycle t produces data_out, valid_out and comma_out at t+1.
  - data_out = candidate[offset_used], where offset_used is the offset value after this cycle's update (see FSM). A realigning comma is therefore itself output aligned.
  - comma_out = comma match on candidate[offset_used].
- FSM (evaluated only on raw_valid cycles; cnt is 2 bits wide, a saturating counter):
  - LOS:
    - if cdet: offset <= ck, cnt <= 1, go to ACQ.
  - ACQ:
    - cdet with ck == offset: cnt++. If cnt reaches ACQ_COMMAS, go to SYNC and clear cnt.
    - cdet with ck != offset: offset <= ck, cnt <= 1.
    - no comma: stay in ACQ, cnt holds.
    - code_err=1: go to LOS.
  - SYNC:
    - offset is frozen; commas at other offsets are ignored.
    - code_err=1: errcnt++. code_err=0: errcnt <= 0.
    - errcnt reaching LOSS_ERRS: go to LOS, synced <= 0.
- synced is registered and equals (state == SYNC).
- code_err is ignored when valid_out was 0 in the previous cycle, and ignored in LOS.
- Simultaneous code_err and comma in ACQ: the error wins and the FSM goes to LOS. The comma is re-evaluated on the next word.

Decomposition:
- Shared package holds:
  - COMMA_P = 7'b0011111 and COMMA_N = 7'b1100000;
  - state encoding LOS=2'd0, ACQ=2'd1, SYNC=2'd2;
  - the symbol width constant 10.
- One natural sub-module: comma_finder, purely combinational.
  - Inputs: win[19:0].
  - Outputs: cdet, ck[3:0], and the 10 candidates.
  - The FSM and output registers stay in the top module.

Test Plan:
- Reset: hold reset_L=0 for 3 cycles with random raw_in → all outputs 0, offset=0, synced=0.
- Acquire at offset 3:
  - Stimulus: repeat K28.5 RD- (0011111010) / RD+ (1100000101) alternately, serialized and shifted 3 bits.
  - Expected: offset=3 from the first comma, and synced=1 after the 3rd comma word.
  - Expected: data_out alternates between 0011111010 and 1100000101.
- Aligned data pass-through:
  - Stimulus: after sync, D21.5 (1010101010), at offset 3.
  - Expected: data_out=1010101010 one cycle after each word, comma_out=0, synced stays 1.
- Realign during ACQ:
  - Stimulus: 2 commas at offset 3, then commas at offset 7.
  - Expected: offset becomes 7, cnt restarts, and synced=1 only after 3 commas at offset 7.
- Loss of sync:
  - Stimulus: in SYNC, pulse code_err for 3 words, one clean word, then 4 errored words.
  - Expected: synced stays 1 through the first error burst and drops exactly after the 4th consecutive error.
  - Expected: FSM is in LOS, and the next comma sets offset.
- Gaps and mid-reset:
  - raw_valid=0 for 5 cycles in ACQ → valid_out=0 and cnt is unchanged.
  - reset_L=0 for one cycle in SYNC → next cycle synced=0 and offset=0.
